// File: rtl/ldpc_dec_ctrl_if.sv
// Frame stream interface of the LDPC iteration controller: channel-LLR input
// handshake and decoded-frame output handshake. The controller takes the
// slave side; the frame source/sink takes the master side.
interface ldpc_dec_ctrl_if #(
  parameter int DATA_W = 5,
  parameter int N_VAR  = 2304,
  parameter int ITER_W = 6
) ();
  logic                      in_valid;
  logic                      in_ready;
  logic [N_VAR*DATA_W-1:0]   in_llr;
  logic                      out_valid;
  logic                      out_ready;
  logic [N_VAR-1:0]          out_dec;
  logic [ITER_W:0]           out_iters;
  logic                      out_conv;

  modport master (
    output in_valid, in_llr, out_ready,
    input  in_ready, out_valid, out_dec, out_iters, out_conv
  );

  modport slave (
    input  in_valid, in_llr, out_ready,
    output in_ready, out_valid, out_dec, out_iters, out_conv
  );
endinterface

// File: rtl/ldpc_dec_ctrl.sv
// Frame-level iteration controller for the parallel LDPC decoder datapath.
// Buffers one frame ahead, loads it into the datapath, steps the CNU/VNU array
// until the parity check passes or the per-frame iteration limit is reached,
// then presents the hard decisions with iteration count and convergence flag.
module ldpc_dec_ctrl #(
  parameter int DATA_W = 5,
  parameter int N_VAR  = 2304,
  parameter int ITER_W = 6,
  parameter int STAT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ldpc_dec_ctrl_if.slave          bus,
  input  logic [ITER_W-1:0]       max_iter,
  output logic [N_VAR*DATA_W-1:0] dp_llr,
  output logic                    dp_clr,
  output logic                    dp_en,
  input  logic [N_VAR-1:0]        dp_dec,
  input  logic                    dp_syn_ok,
  output logic                    busy,
  output logic [STAT_W-1:0]       stat_ok,
  output logic [STAT_W-1:0]       stat_fail
);

  localparam int LLR_W = N_VAR * DATA_W;
  localparam int CNT_W = ITER_W + 1;
  // A max_iter of zero stands for the largest limit, 2^ITER_W.
  localparam logic [CNT_W-1:0] MAX_LIMIT = CNT_W'(1) << ITER_W;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

  state_e              state_q, state_d;
  logic [LLR_W-1:0]    buf_q;
  logic                buf_full_q, buf_full_d;
  logic [LLR_W-1:0]    dp_llr_q, dp_llr_d;
  logic [CNT_W-1:0]    iter_cnt_q, iter_cnt_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [N_VAR-1:0]    out_dec_q, out_dec_d;
  logic [CNT_W-1:0]    out_iters_q, out_iters_d;
  logic                out_conv_q, out_conv_d;
  logic                out_valid_q, out_valid_d;
  logic [STAT_W-1:0]   stat_ok_q, stat_ok_d;
  logic [STAT_W-1:0]   stat_fail_q, stat_fail_d;
  logic                accept;

  assign accept = bus.in_valid & ~buf_full_q;

  // Next-state, datapath strobes and result capture for the frame FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    dp_llr_d    = dp_llr_q;
    iter_cnt_d  = iter_cnt_q;
    limit_d     = limit_q;
    out_dec_d   = out_dec_q;
    out_iters_d = out_iters_q;
    out_conv_d  = out_conv_q;
    out_valid_d = out_valid_q;
    stat_ok_d   = stat_ok_q;
    stat_fail_d = stat_fail_q;
    dp_clr      = 1'b0;
    dp_en       = 1'b0;

    // Accepting needs an empty buffer and draining needs a full one, so the
    // drain below can never collide with a same-cycle accept.
    if (accept) buf_full_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (buf_full_q) begin
          dp_llr_d   = buf_q;
          buf_full_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        dp_clr     = 1'b1;
        iter_cnt_d = '0;
        limit_d    = (max_iter == '0) ? MAX_LIMIT : CNT_W'(max_iter);
        state_d    = ITER;
      end
      ITER: begin
        if (dp_syn_ok) begin
          out_dec_d   = dp_dec;
          out_iters_d = iter_cnt_q;
          out_conv_d  = 1'b1;
          out_valid_d = 1'b1;
          if (stat_ok_q != '1) stat_ok_d = stat_ok_q + 1'b1;
          state_d     = DONE;
        end else if (iter_cnt_q == limit_q) begin
          out_dec_d   = dp_dec;
          out_iters_d = limit_q;
          out_conv_d  = 1'b0;
          out_valid_d = 1'b1;
          if (stat_fail_q != '1) stat_fail_d = stat_fail_q + 1'b1;
          state_d     = DONE;
        end else begin
          dp_en      = 1'b1;
          iter_cnt_d = iter_cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (buf_full_q) begin
            dp_llr_d   = buf_q;
            buf_full_d = 1'b0;
            state_d    = LOAD;
          end else begin
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      buf_full_q  <= 1'b0;
      dp_llr_q    <= '0;
      iter_cnt_q  <= '0;
      limit_q     <= '0;
      out_dec_q   <= '0;
      out_iters_q <= '0;
      out_conv_q  <= 1'b0;
      out_valid_q <= 1'b0;
      stat_ok_q   <= '0;
      stat_fail_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_full_q  <= buf_full_d;
      dp_llr_q    <= dp_llr_d;
      iter_cnt_q  <= iter_cnt_d;
      limit_q     <= limit_d;
      out_dec_q   <= out_dec_d;
      out_iters_q <= out_iters_d;
      out_conv_q  <= out_conv_d;
      out_valid_q <= out_valid_d;
      stat_ok_q   <= stat_ok_d;
      stat_fail_q <= stat_fail_d;
    end
  end

  // Skid-buffer payload capture on an accepted input frame.
  always_ff @(posedge clk) begin
    // NOTE: the frame payload has no reset; buf_full_q alone says whether it
    // holds anything, so clearing the wide storage would buy nothing.
    if (accept) buf_q <= bus.in_llr;
  end

  assign bus.in_ready  = ~buf_full_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_dec   = out_dec_q;
  assign bus.out_iters = out_iters_q;
  assign bus.out_conv  = out_conv_q;
  assign dp_llr        = dp_llr_q;
  assign busy          = (state_q != IDLE);
  assign stat_ok       = stat_ok_q;
  assign stat_fail     = stat_fail_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Directed bench for ldpc_dec_ctrl. A small datapath stand-in counts dp_en
// pulses since the last dp_clr, derives dp_dec from that count and raises
// dp_syn_ok once a chosen number of iterations has been stepped.
module tb_ldpc_dec_ctrl;
  localparam int DATA_W = 5;
  localparam int N_VAR  = 16;
  localparam int ITER_W = 6;
  localparam int STAT_W = 2;
  localparam int LLR_W  = N_VAR * DATA_W;

  localparam logic [N_VAR-1:0] DEC_BASE = 16'hA5A0;
  localparam logic [LLR_W-1:0] F1  = 80'h0123456789ABCDEF0011;
  localparam logic [LLR_W-1:0] F2  = 80'h13579BDF02468ACE1357;
  localparam logic [LLR_W-1:0] F3  = 80'h2468ACE013579BDF2468;
  localparam logic [LLR_W-1:0] F4  = 80'h0F1E2D3C4B5A69788796;
  localparam logic [LLR_W-1:0] F5A = 80'hAAAAAAAAAAAAAAAAAAAA;
  localparam logic [LLR_W-1:0] F5B = 80'h5555555555555555555F;
  localparam logic [LLR_W-1:0] F5C = 80'hC3C3C3C3C3C3C3C3C3C3;
  localparam logic [LLR_W-1:0] F6  = 80'hFEDCBA9876543210FFFF;
  localparam logic [LLR_W-1:0] F7  = 80'h0F0F0F0F0F0F0F0F0F0F;

  logic                clk = 1'b0;
  logic                rst;
  logic [ITER_W-1:0]   max_iter;
  logic [LLR_W-1:0]    dp_llr;
  logic                dp_clr;
  logic                dp_en;
  logic [N_VAR-1:0]    dp_dec;
  logic                dp_syn_ok;
  logic                busy;
  logic [STAT_W-1:0]   stat_ok;
  logic [STAT_W-1:0]   stat_fail;

  int   n_vec = 0;
  int   n_err = 0;
  logic syn_enable;
  int   syn_after;
  int   en_cnt = 0;
  int   en_total = 0;
  int   overlap = 0;

  always #5 clk = ~clk;

  ldpc_dec_ctrl_if #(.DATA_W(DATA_W), .N_VAR(N_VAR), .ITER_W(ITER_W)) bus ();

  ldpc_dec_ctrl #(
    .DATA_W(DATA_W), .N_VAR(N_VAR), .ITER_W(ITER_W), .STAT_W(STAT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .max_iter  (max_iter),
    .dp_llr    (dp_llr),
    .dp_clr    (dp_clr),
    .dp_en     (dp_en),
    .dp_dec    (dp_dec),
    .dp_syn_ok (dp_syn_ok),
    .busy      (busy),
    .stat_ok   (stat_ok),
    .stat_fail (stat_fail)
  );

  // Datapath stand-in: iteration count since the last clear.
  assign dp_dec    = DEC_BASE ^ N_VAR'(en_cnt);
  assign dp_syn_ok = syn_enable && (en_cnt >= syn_after);

  always @(posedge clk) begin
    if (dp_clr) en_cnt <= 0;
    else if (dp_en) en_cnt <= en_cnt + 1;
    if (dp_en) en_total <= en_total + 1;
    if (dp_clr && dp_en) overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one frame; returns at the falling edge after the accept edge.
  task automatic send(input logic [LLR_W-1:0] llr);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send in_ready", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_llr   = llr;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!bus.out_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("out_valid timeout", bus.out_valid, 1'b1);
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("pop out_valid", bus.out_valid, 1'b0);
  endtask

  initial begin
    int rdy_hi;
    int ov_lo;
    int n;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_llr    = '0;
    bus.out_ready = 1'b0;
    max_iter      = 6'd4;
    syn_enable    = 1'b1;
    syn_after     = 0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst dp_llr", dp_llr, '0);
    check("rst out_iters", bus.out_iters, '0);
    check("rst stat_ok", stat_ok, '0);
    check("rst stat_fail", stat_fail, '0);
    rst = 1'b0;
    @(negedge clk);

    // Frame converging in the first ITER cycle: E0 accept, E1 LOAD, E2 ITER, E3 out.
    send(F1);
    check("f1 buffered in_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    check("f1 load dp_clr", dp_clr, 1'b1);
    check("f1 load dp_llr", dp_llr, F1);
    check("f1 load in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    check("f1 iter out_valid", bus.out_valid, 1'b0);
    check("f1 iter dp_en", dp_en, 1'b0);
    @(negedge clk);
    check("f1 out_valid", bus.out_valid, 1'b1);
    check("f1 out_iters", bus.out_iters, 7'd0);
    check("f1 out_conv", bus.out_conv, 1'b1);
    check("f1 out_dec", bus.out_dec, DEC_BASE);
    check("f1 stat_ok", stat_ok, 2'd1);
    check("f1 no dp_en", en_total, 0);
    pop();

    // Limit of 4 reached without convergence.
    syn_enable = 1'b0;
    send(F2);
    wait_out();
    check("f2 en pulses", en_cnt, 4);
    check("f2 out_iters", bus.out_iters, 7'd4);
    check("f2 out_conv", bus.out_conv, 1'b0);
    check("f2 out_dec", bus.out_dec, DEC_BASE ^ 16'd4);
    check("f2 stat_fail", stat_fail, 2'd1);
    check("f2 stat_ok", stat_ok, 2'd1);
    pop();

    // max_iter=0 means 64; changing max_iter after LOAD has no effect.
    max_iter = 6'd0;
    send(F3);
    @(negedge clk);
    @(negedge clk);
    max_iter = 6'd4;
    wait_out();
    check("f3 en pulses", en_cnt, 64);
    check("f3 out_iters", bus.out_iters, 7'd64);
    check("f3 out_conv", bus.out_conv, 1'b0);
    check("f3 stat_fail", stat_fail, 2'd2);
    pop();

    // Parity satisfied after the third step.
    max_iter   = 6'd10;
    syn_enable = 1'b1;
    syn_after  = 3;
    send(F4);
    wait_out();
    check("f4 out_iters", bus.out_iters, 7'd3);
    check("f4 out_conv", bus.out_conv, 1'b1);
    check("f4 out_dec", bus.out_dec, DEC_BASE ^ 16'd3);
    check("f4 stat_ok", stat_ok, 2'd2);
    pop();

    // Back-pressure: one frame buffered behind a stalled result.
    syn_after = 0;
    send(F5A);
    wait_out();
    check("f5a stat_ok", stat_ok, 2'd3);
    send(F5B);
    check("f5b buffered in_ready", bus.in_ready, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_llr   = F5C;
    rdy_hi = 0;
    ov_lo  = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.in_ready) rdy_hi++;
      if (!bus.out_valid) ov_lo++;
    end
    bus.in_valid = 1'b0;
    check("stall in_ready highs", rdy_hi, 0);
    check("stall out_valid drops", ov_lo, 0);
    check("stall out_dec held", bus.out_dec, DEC_BASE);
    check("stall dp_llr held", dp_llr, F5A);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release dp_clr", dp_clr, 1'b1);
    check("release dp_llr", dp_llr, F5B);
    check("release out_valid", bus.out_valid, 1'b0);
    check("release in_ready", bus.in_ready, 1'b1);
    wait_out();
    check("f5b out_iters", bus.out_iters, 7'd0);
    check("f5b stat_ok saturated", stat_ok, 2'd3);
    pop();
    send(F5C);
    wait_out();
    check("f5c dp_llr", dp_llr, F5C);
    check("f5c stat_ok saturated", stat_ok, 2'd3);
    pop();

    // Asynchronous reset in the middle of ITER.
    syn_enable = 1'b0;
    max_iter   = 6'd10;
    send(F6);
    n = 0;
    while (en_cnt != 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("f6 reached iter 2", en_cnt, 2);
    rst = 1'b1;
    #1;
    check("mid rst dp_llr", dp_llr, '0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst dp_en", dp_en, 1'b0);
    check("mid rst out_valid", bus.out_valid, 1'b0);
    check("mid rst out_iters", bus.out_iters, '0);
    check("mid rst out_conv", bus.out_conv, 1'b0);
    check("mid rst out_dec", bus.out_dec, '0);
    check("mid rst stat_ok", stat_ok, '0);
    check("mid rst stat_fail", stat_fail, '0);
    check("mid rst in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Normal decode after reset.
    syn_enable = 1'b1;
    syn_after  = 1;
    max_iter   = 6'd4;
    send(F7);
    wait_out();
    check("f7 dp_llr", dp_llr, F7);
    check("f7 out_iters", bus.out_iters, 7'd1);
    check("f7 out_conv", bus.out_conv, 1'b1);
    check("f7 out_dec", bus.out_dec, DEC_BASE ^ 16'd1);
    check("f7 stat_ok", stat_ok, 2'd1);
    check("f7 stat_fail", stat_fail, 2'd0);
    pop();
    check("clr/en overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ldpc_dec_ctrl.md
Name: ldpc_dec_ctrl

Overview:
Frame-level iteration controller for the parallel LDPC decoder datapath (CNU/VNU array plus parity check). It generalises the fixed 32-iteration, single-frame control of the current core:
- valid/ready input and output handshakes
- one-frame input skid buffer, so the next frame loads while the current one decodes
- programmable per-frame iteration limit
- iteration count and convergence reporting
- saturating pass/fail frame statistics

The datapath stays in its existing modules; this block drives its LLR, clear and step-enable inputs.

Parameters:
DATA_W, 5, LLR width per variable node
N_VAR, 2304, variable nodes per frame (R*D of the datapath)
ITER_W, 6, width of max_iter; limit range 1..2^ITER_W
STAT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input frame valid
in_ready  out  1  input buffer can accept a frame
in_llr  in  N_VAR*DATA_W  channel LLRs for the frame
max_iter  in  ITER_W  iteration limit; 0 encodes 2^ITER_W
dp_llr  out  N_VAR*DATA_W  working LLRs to the VNUs (registered)
dp_clr  out  1  one-cycle clear of CNU state
dp_en  out  1  advance datapath by one iteration this cycle
dp_dec  in  N_VAR  hard decisions of the current datapath state (combinational)
dp_syn_ok  in  1  1 = all parity checks satisfied for dp_dec
out_valid  out  1  decoded frame available
out_ready  in  1  sink accepts the decoded frame
out_dec  out  N_VAR  decoded bits (registered)
out_iters  out  ITER_W+1  iterations executed
out_conv  out  1  1 = converged, 0 = limit reached
busy  out  1  state != IDLE
stat_ok  out  STAT_W  converged frame count, saturating
stat_fail  out  STAT_W  non-converged frame count, saturating

Behaviour:
- Reset (async): state=IDLE; buf_full=0; dp_llr=0; out_dec=0; out_iters=0; out_conv=0; out_valid=0; stat_ok=0; stat_fail=0. Any frame in progress or buffered is discarded.
- Skid buffer:
  - in_ready = ~buf_full, driven from a register.
  - in_valid & in_ready at a rising edge: buf <= in_llr, buf_full <= 1.
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - If buf_full: dp_llr <= buf, buf_full <= 0, go to LOAD.
  - A frame accepted in the same cycle is held in buf, not loaded directly.
- LOAD (one cycle):
  - dp_clr=1.
  - iter_cnt <= 0.
  - limit <= (max_iter==0) ? 2^ITER_W : max_iter. max_iter is sampled only here.
  - Go to ITER.
- ITER: each cycle, evaluated in priority order:
  - dp_syn_ok=1: out_dec <= dp_dec; out_iters <= iter_cnt; out_conv <= 1; stat_ok++ (saturating); go to DONE.
  - Otherwise, iter_cnt==limit: out_dec <= dp_dec; out_iters <= limit; out_conv <= 0; stat_fail++ (saturating); go to DONE.
  - Otherwise: iter_cnt++.
  - dp_en = ITER & ~dp_syn_ok & (iter_cnt != limit), decoded combinationally. No step is issued in the terminating cycle.
- DONE:
  - out_valid=1. out_* is held stable until the handshake.
  - On out_valid & out_ready: out_valid <= 0. Next state is LOAD if buf_full (buf moved to dp_llr, buf_full <= 0), else IDLE.
- Latency: accept edge E0 → LOAD after E1 → ITER after E2. A frame already valid from the channel gives out_valid after E3 with out_iters=0. Each extra iteration adds one cycle.
- Counters stop at 2^STAT_W-1 and do not wrap.
- dp_clr and dp_en are never high in the same cycle. dp_en=0 in IDLE, LOAD and DONE.
- Back-pressure: while DONE stalls, at most one further frame is buffered. in_ready stays 0 until the buffer drains.

Test Plan:
- Reset: max_iter=4. Frame with dp_syn_ok=1 from the first ITER cycle → out_valid 3 cycles after accept; out_iters=0, out_conv=1, stat_ok=1, dp_en never asserted.
- max_iter=4, dp_syn_ok held 0 → exactly 4 dp_en pulses; out_iters=4, out_conv=0, stat_fail=1.
- max_iter=0, dp_syn_ok=0 → 64 dp_en pulses (ITER_W=6); out_iters=64.
- dp_syn_ok rises after 3rd dp_en → out_iters=3, out_conv=1; out_dec equals the dp_dec value at that cycle.
- out_ready=0 for 10 cycles; send 2 more frames → second accepted, third sees in_ready=0. On release, LOAD follows DONE directly with no IDLE cycle, and dp_llr equals the second frame.
- Assert rst mid-ITER (iter_cnt=2) → all outputs zero immediately; in_ready=1; the next frame decodes normally.
